// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic {
        CPU = 1'b0,
        EXT = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin picker: req[0] is the CPU, req[1] the external port.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] gnt,
    output owner_t     owner
);

    // Single requester wins outright; on a tie the side not granted last wins.
    always_comb begin
        owner = CPU;
        gnt   = '0;
        case (req)
            2'b01:   owner = CPU;
            2'b10:   owner = EXT;
            2'b11:   owner = (last == CPU) ? EXT : CPU;
            default: owner = CPU;
        endcase
        if (req != 2'b00) begin
            gnt = (owner == EXT) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM-stage load/store
// path and an external port, sequencing each access through a fixed latency.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int width = 32,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             start,
    input  logic             cpu_memRead,
    input  logic             cpu_memWrite,
    input  logic [width-1:0] cpu_addr,
    input  logic [width-1:0] cpu_wdata,
    output logic [width-1:0] cpu_rdata,
    output logic             cpu_stall,
    input  logic             ext_req,
    input  logic             ext_we,
    input  logic [width-1:0] ext_addr,
    input  logic [width-1:0] ext_wdata,
    output logic             ext_ack,
    output logic [width-1:0] ext_rdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [width-1:0] mem_addr,
    output logic [width-1:0] mem_wdata,
    input  logic [width-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    owner_t             owner_q, owner_d;
    owner_t             last_q, last_d;
    logic [width-1:0]   addr_q, addr_d;
    logic               write_q, write_d;
    logic [width-1:0]   rdata_q, rdata_d;

    logic               cpu_req;
    logic [1:0]         req;
    logic [1:0]         gnt;
    owner_t             win;
    logic               issue;
    logic               win_write;
    logic [width-1:0]   win_addr;
    logic [width-1:0]   win_wdata;

    assign cpu_req = cpu_memRead | cpu_memWrite;
    // Requests only compete while idle; BUSY/DONE never issue.
    assign req     = (state_q == IDLE) ? {ext_req, cpu_req} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (last_q),
        .gnt   (gnt),
        .owner (win)
    );

    // No issue while reset is asserted, so strobes stay low during reset.
    assign issue     = (|gnt) & ~start;
    // A CPU request with both read and write high is treated as a write.
    assign win_write = (win == EXT) ? ext_we    : cpu_memWrite;
    assign win_addr  = (win == EXT) ? ext_addr  : cpu_addr;
    assign win_wdata = (win == EXT) ? ext_wdata : cpu_wdata;

    // Next-state, counter and memory-side outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        write_d   = write_q;
        rdata_d   = rdata_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    mem_addr  = win_addr;
                    mem_wdata = win_wdata;
                    mem_read  = ~win_write;
                    mem_write = win_write;
                    owner_d   = win;
                    last_d    = win;
                    addr_d    = win_addr;
                    write_d   = win_write;
                    cnt_d     = CNT_LOAD;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    if (!write_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (start) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= CPU;
            last_q  <= EXT;
            addr_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    assign cpu_stall = cpu_req & ~((state_q == DONE) & (owner_q == CPU));
    assign ext_ack   = (state_q == DONE) & (owner_q == EXT);
    assign cpu_rdata = rdata_q;
    assign ext_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a LAT=1 instance driven from a cycle
// table and a LAT=3 instance driven by a hand-written sequence.
module tb_dmem_arbiter;

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] KV = 32'h12345678;
    localparam logic [31:0] A5 = 32'hA5A50011;
    localparam logic [31:0] CF = 32'hCAFEF00D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // LAT=1 instance signals
    logic        a_start = 1'b1, a_crd = 1'b0, a_cwr = 1'b0;
    logic [31:0] a_caddr = '0, a_cwdata = '0;
    logic        a_ereq = 1'b0, a_ewe = 1'b0;
    logic [31:0] a_eaddr = '0, a_ewdata = '0;
    logic [31:0] a_crdata, a_erdata, a_maddr, a_mwdata, a_mrdata;
    logic        a_stall, a_ack, a_mrd, a_mwr;

    // LAT=3 instance signals
    logic        b_start = 1'b1, b_crd = 1'b0, b_cwr = 1'b0;
    logic [31:0] b_caddr = '0, b_cwdata = '0;
    logic [31:0] b_crdata, b_erdata, b_maddr, b_mwdata, b_mrdata;
    logic        b_stall, b_ack, b_mrd, b_mwr;

    dmem_arbiter #(.width(32), .LAT(1)) u_dut1 (
        .clk(clk), .start(a_start),
        .cpu_memRead(a_crd), .cpu_memWrite(a_cwr), .cpu_addr(a_caddr), .cpu_wdata(a_cwdata),
        .cpu_rdata(a_crdata), .cpu_stall(a_stall),
        .ext_req(a_ereq), .ext_we(a_ewe), .ext_addr(a_eaddr), .ext_wdata(a_ewdata),
        .ext_ack(a_ack), .ext_rdata(a_erdata),
        .mem_read(a_mrd), .mem_write(a_mwr), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
        .mem_rdata(a_mrdata)
    );

    dmem_arbiter #(.width(32), .LAT(3)) u_dut3 (
        .clk(clk), .start(b_start),
        .cpu_memRead(b_crd), .cpu_memWrite(b_cwr), .cpu_addr(b_caddr), .cpu_wdata(b_cwdata),
        .cpu_rdata(b_crdata), .cpu_stall(b_stall),
        .ext_req(1'b0), .ext_we(1'b0), .ext_addr(32'h0), .ext_wdata(32'h0),
        .ext_ack(b_ack), .ext_rdata(b_erdata),
        .mem_read(b_mrd), .mem_write(b_mwr), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
        .mem_rdata(b_mrdata)
    );

    // Memory model, latency 1; preloaded while reset is asserted.
    logic [31:0] mem1 [0:255];
    always @(posedge clk) begin
        if (a_start) begin
            mem1[8'h10] <= DB;
            mem1[8'h11] <= A5;
        end
        if (a_mwr) mem1[a_maddr[7:0]] <= a_mwdata;
        a_mrdata <= mem1[a_maddr[7:0]];
    end

    // Memory model, latency 3.
    logic [31:0] mem3 [0:255];
    logic [31:0] p3 [0:2];
    always @(posedge clk) begin
        if (b_mwr) mem3[b_maddr[7:0]] <= b_mwdata;
        p3[0] <= mem3[b_maddr[7:0]];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b_mrdata = p3[2];

    typedef struct {
        logic        st, cr, cw;
        logic [7:0]  ca;
        logic        er, ew;
        logic [7:0]  ea;
        logic [31:0] wd;
        logic        stall, ack, rd, wr;
        int          xa;     // expected mem_addr, negative = don't check
        int          rsel;   // 0 none, 1 cpu_rdata, 2 ext_rdata
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, cr, cw, input logic [7:0] ca,
                                input logic er, ew, input logic [7:0] ea, input logic [31:0] wd,
                                input logic stall, ack, rd, wr, input int xa, input int rsel,
                                input logic [31:0] rdata);
        vec_t v;
        v.st = st; v.cr = cr; v.cw = cw; v.ca = ca;
        v.er = er; v.ew = ew; v.ea = ea; v.wd = wd;
        v.stall = stall; v.ack = ack; v.rd = rd; v.wr = wr;
        v.xa = xa; v.rsel = rsel; v.rdata = rdata;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    endtask

    initial begin
        //            st cr cw ca     er ew ea     wd   | stall ack rd wr  xa     rsel rdata
        vecs.push_back(mk(1, 1, 0, 8'h10, 0, 0, 8'h00, 0,  1, 0, 0, 0, 'h00, 1, 0));  // 0 reset
        vecs.push_back(mk(0, 1, 0, 8'h10, 0, 0, 8'h00, 0,  1, 0, 1, 0, 'h10, 0, 0));  // 1 cpu load issue
        vecs.push_back(mk(0, 1, 0, 8'h10, 0, 0, 8'h00, 0,  1, 0, 0, 0, 'h10, 0, 0));  // 2 busy
        vecs.push_back(mk(0, 1, 0, 8'h10, 0, 0, 8'h00, 0,  0, 0, 0, 0, -1,   1, DB)); // 3 done
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 8'h20, KV, 0, 0, 0, 1, 'h20, 0, 0));  // 4 ext write
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 8'h20, KV, 0, 0, 0, 0, 'h20, 0, 0));  // 5
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 8'h20, KV, 0, 1, 0, 0, -1,   0, 0));  // 6 ack
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 0, -1,   0, 0));  // 7
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h20, 0,  0, 0, 1, 0, 'h20, 0, 0));  // 8 ext read
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h20, 0,  0, 0, 0, 0, -1,   0, 0));  // 9
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h20, 0,  0, 1, 0, 0, -1,   2, KV)); // 10
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 0, -1,   0, 0));  // 11
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 0, -1,   0, 0));  // 12 reset
        vecs.push_back(mk(0, 1, 0, 8'h10, 1, 0, 8'h20, 0,  1, 0, 1, 0, 'h10, 1, 0));  // 13 tie -> cpu
        vecs.push_back(mk(0, 1, 0, 8'h10, 1, 0, 8'h20, 0,  1, 0, 0, 0, -1,   0, 0));  // 14
        vecs.push_back(mk(0, 1, 0, 8'h10, 1, 0, 8'h20, 0,  0, 0, 0, 0, -1,   1, DB)); // 15
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 8'h20, 0,  1, 0, 1, 0, 'h20, 0, 0));  // 16 tie -> ext
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 8'h20, 0,  1, 0, 0, 0, -1,   0, 0));  // 17
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 8'h20, 0,  1, 1, 0, 0, -1,   2, KV)); // 18
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 8'h20, 0,  1, 0, 1, 0, 'h11, 0, 0));  // 19 tie -> cpu
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 8'h20, 0,  1, 0, 0, 0, -1,   0, 0));  // 20
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 8'h20, 0,  0, 0, 0, 0, -1,   1, A5)); // 21
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 8'h20, 0,  1, 0, 1, 0, 'h20, 0, 0));  // 22 tie -> ext
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 8'h20, 0,  1, 0, 0, 0, -1,   0, 0));  // 23
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 8'h20, 0,  1, 1, 0, 0, -1,   2, KV)); // 24
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 0, -1,   0, 0));  // 25
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h20, 0,  0, 0, 1, 0, 'h20, 0, 0));  // 26 ext issue
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h20, 0,  0, 0, 0, 0, 'h20, 0, 0));  // 27 req dropped
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h20, 0,  0, 1, 0, 0, -1,   2, KV)); // 28 still acks
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 0, -1,   0, 0));  // 29
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 0, -1,   0, 0));  // 30
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h10, 0,  0, 0, 1, 0, 'h10, 0, 0));  // 31 ext issue
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h10, 0,  0, 0, 0, 0, -1,   0, 0));  // 32 reset in busy
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 8'h10, 0,  1, 0, 1, 0, 'h11, 1, 0));  // 33 tie -> cpu
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 8'h10, 0,  1, 0, 0, 0, -1,   0, 0));  // 34
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 8'h10, 0,  0, 0, 0, 0, -1,   1, A5)); // 35
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h10, 0,  0, 0, 1, 0, 'h10, 0, 0));  // 36
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h10, 0,  0, 0, 0, 0, -1,   0, 0));  // 37
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h10, 0,  0, 1, 0, 0, -1,   2, DB)); // 38
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 0, -1,   0, 0));  // 39

        repeat (2) @(posedge clk);

        // LAT=1 cycle table
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            a_start  = vecs[i].st;
            a_crd    = vecs[i].cr;
            a_cwr    = vecs[i].cw;
            a_caddr  = {24'h0, vecs[i].ca};
            a_cwdata = vecs[i].wd;
            a_ereq   = vecs[i].er;
            a_ewe    = vecs[i].ew;
            a_eaddr  = {24'h0, vecs[i].ea};
            a_ewdata = vecs[i].wd;
            #1;
            check("cpu_stall", i, {31'h0, a_stall}, {31'h0, vecs[i].stall});
            check("ext_ack",   i, {31'h0, a_ack},   {31'h0, vecs[i].ack});
            check("mem_read",  i, {31'h0, a_mrd},   {31'h0, vecs[i].rd});
            check("mem_write", i, {31'h0, a_mwr},   {31'h0, vecs[i].wr});
            if (vecs[i].xa >= 0) check("mem_addr", i, a_maddr, 32'(vecs[i].xa));
            if (vecs[i].wr) check("mem_wdata", i, a_mwdata, vecs[i].wd);
            if (vecs[i].rsel == 1) check("cpu_rdata", i, a_crdata, vecs[i].rdata);
            if (vecs[i].rsel == 2) check("ext_rdata", i, a_erdata, vecs[i].rdata);
        end

        // LAT=3: store with simultaneous read, then read back
        @(negedge clk);
        b_start = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            int st_cnt, wr_cnt, rd_cnt;
            bit released;
            st_cnt = 0; wr_cnt = 0; rd_cnt = 0; released = 1'b0;
            @(negedge clk);
            b_crd    = 1'b1;
            b_cwr    = (pass == 0);
            b_caddr  = 32'h40;
            b_cwdata = CF;
            for (int c = 0; c < 12 && !released; c++) begin
                #1;
                if (b_mwr) wr_cnt++;
                if (b_mrd) rd_cnt++;
                if (b_stall) begin
                    st_cnt++;
                    @(negedge clk);
                end else begin
                    released = 1'b1;
                end
            end
            check("lat3_release", pass, {31'h0, released}, 32'h1);
            check("lat3_stall_cycles", pass, st_cnt, 4);
            check("lat3_write_pulses", pass, wr_cnt, (pass == 0) ? 1 : 0);
            check("lat3_read_pulses", pass, rd_cnt, (pass == 0) ? 0 : 1);
            check("lat3_cpu_rdata", pass, b_crdata, (pass == 0) ? 32'h0 : CF);
            @(negedge clk);
            b_crd = 1'b0;
            b_cwr = 1'b0;
            if (pass == 0) check("lat3_mem_content", pass, mem3[8'h40], CF);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d of %0d checks passed", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-port data memory used by the MEM stage. Shares the memory between the pipeline's load/store path and an external port used for loading, inspecting or DMA access. Serialises accesses, waits a fixed memory latency, and returns read data. Stalls the pipeline while its access is pending or blocked. Sits between the MEM-stage control/ALU outputs and the data memory instance.

## Interface
Parameters:
- `width`, 32: data and address width.
- `LAT`, 1: memory read latency in cycles from issue to valid `mem_rdata`. Legal range is 1..7.

Ports:
- `clk`, in, 1: clock, rising edge.
- `start`, in, 1: reset, synchronous and active-high.
- `cpu_memRead`, in, 1: MEM-stage load request.
- `cpu_memWrite`, in, 1: MEM-stage store request.
- `cpu_addr`, in, width: ALU result address.
- `cpu_wdata`, in, width: store data (rd2).
- `cpu_rdata`, out, width: load data, valid while state is DONE and owner is CPU.
- `cpu_stall`, out, 1: freeze pipeline.
- `ext_req`, in, 1: external request; held until `ext_ack`.
- `ext_we`, in, 1: 1 means write, 0 means read.
- `ext_addr`, in, width: external address.
- `ext_wdata`, in, width: external write data.
- `ext_ack`, out, 1: one-cycle completion pulse.
- `ext_rdata`, out, width: read data, valid with `ext_ack`.
- `mem_read`, out, 1: memory read strobe.
- `mem_write`, out, 1: memory write strobe.
- `mem_addr`, out, width: memory address.
- `mem_wdata`, out, width: memory write data.
- `mem_rdata`, in, width: memory read data.

## Operation
- FSM has three states:
  - IDLE: arbitrate and issue.
  - BUSY: wait for the latency counter.
  - DONE: present the result for one cycle, with no issue.
- A CPU request is `cpu_memRead | cpu_memWrite`. If both are high, the access is a write.
- Arbitration happens in IDLE only:
  - If exactly one side requests, that side is granted.
  - If both request, grant goes to the side not granted last (`last_grant` bit).
- Issue cycle (IDLE to BUSY):
  - `mem_addr`/`mem_wdata` come from the winner.
  - `mem_read`/`mem_write` are high for this cycle only.
  - Owner, address and direction are latched.
  - `cnt` is loaded with LAT-1.
  - `last_grant` is updated to the winner.
- BUSY:
  - Strobes are low; `mem_addr` holds the latched address.
  - `cnt` decrements each cycle.
  - When `cnt==0`, `mem_rdata` is captured into `rdata_q` (reads only) and the state moves to DONE.
- DONE:
  - For a CPU owner, `cpu_stall` is low.
  - For an EXT owner, `ext_ack` is high.
  - The next state is always IDLE.
- `cpu_stall = cpu_req & !(state==DONE & owner==CPU)`. This is combinational, so the stall also covers the cycle of a lost arbitration.
- Writes also complete through BUSY and DONE, so every access has uniform latency. `rdata_q` is unchanged by writes.
- If `ext_req` drops mid-access, the access still completes and `ext_ack` still pulses.
- Reset (`start` high at a rising edge), at any state including mid-access:
  - State goes to IDLE and `cnt` to 0.
  - `last_grant` is set to EXT, so the CPU wins the first tie.
  - `rdata_q` is cleared to 0.
  - Any in-flight access is abandoned with no ack.

## Timing
- Reset values of outputs:
  - `cpu_stall` follows its combinational equation, so it is 1 iff a CPU request is present.
  - `ext_ack`, `mem_read` and `mem_write` are 0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata` and `ext_rdata` are 0.
- A request issued at cycle T has read data sampled at the end of T+LAT, and completes in DONE at T+LAT+1.
- An uncontended CPU access therefore stalls for LAT+1 cycles and is released in cycle T+LAT+1.
- The minimum spacing between back-to-back issues is LAT+2 cycles.
- Worst-case CPU wait under continuous EXT traffic is one EXT access (LAT+2 cycles) plus its own access.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum {IDLE, BUSY, DONE};
  - the owner encoding (CPU=0, EXT=1);
  - the localparam `CNT_W`=3.
- One sub-module, `rr_arb2`: a two-requester round-robin picker. Inputs are `req[1:0]` and `last`; outputs are a one-hot `gnt` and `owner`. It is purely combinational.
- The FSM, counter and datapath muxing live in `dmem_arbiter`.

## Test plan
- Reset, then an idle CPU load at addr 0x10 with memory preloaded with 0xDEADBEEF and LAT=1:
  - `mem_read` pulses at T;
  - `cpu_stall` is high for T..T+1 and low at T+2;
  - `cpu_rdata`=0xDEADBEEF at T+2.
- EXT write of 0x12345678 to 0x20, then an EXT read of 0x20: `ext_ack` pulses once per access, and the read gives `ext_rdata`=0x12345678.
- CPU and EXT request in the same cycle after reset:
  - CPU is served first;
  - EXT is served next;
  - on a repeated tie, grants alternate CPU, EXT, CPU.
- LAT=3, CPU store to 0x40 with a simultaneous `cpu_memRead`: only `mem_write` pulses, and `cpu_stall` is high for exactly 4 cycles.
- `start` asserted in BUSY of an EXT read:
  - state returns to IDLE;
  - no `ext_ack` is produced;
  - the next request issues normally with CPU tie priority.
- `ext_req` dropped one cycle after issue: DONE is still reached and `ext_ack` pulses once; no new issue occurs while `ext_req` is low.
